icache_fetch: RTL
=================

Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the instruction-fetch unit and the memory controller.
- Serves 32-bit instruction words to fetch with a combinational hit path.
- On a miss, requests a whole line from the memory controller through the if_en / if_pc / if_done / if_data handshake, then installs the line.
- One miss is outstanding at most; the miss runs to completion even across pipeline rollback.

Parameters:
- LINE_BYTES, 64, bytes per line; must equal the memory controller's line size; power of two ≥ 4.
- SET_NUM, 16, number of lines; power of two.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state holds.
- rollback  in  1  pipeline flush from the ROB.
- fetch_en  in  1  fetch unit requests an instruction this cycle.
- fetch_pc  in  ADDR_W  instruction address; bits [1:0] ignored.
- fetch_hit  out  1  combinational; fetch_inst valid this cycle.
- fetch_inst  out  32  instruction word, little-endian, from the line.
- mem_en  out  1  line request to the memory controller (its if_en).
- mem_pc  out  ADDR_W  line-aligned request address (its if_pc).
- mem_done  in  1  one-cycle pulse; line data valid (its if_done).
- mem_line  in  8*LINE_BYTES  line data; byte i at bits [8i+7:8i] (its if_data).

Behaviour:
- Address split:
  - OFF = log2(LINE_BYTES); IDX = log2(SET_NUM).
  - offset = pc[OFF-1:2] as a word index; index = pc[OFF+IDX-1:OFF]; tag = pc[ADDR_W-1:OFF+IDX].
- Storage: valid[SET_NUM], tag[SET_NUM], data[SET_NUM] of 8*LINE_BYTES bits.
- Hit path:
  - fetch_hit = fetch_en & valid[index] & (tag[index]==tag) & (state==IDLE).
  - fetch_inst = bytes {off+3, off+2, off+1, off} of data[index], where off = word offset*4.
  - fetch_inst is don't-care when fetch_hit=0.
- State machine:
  - IDLE:
    - If rdy & fetch_en & not a hit: latch the line address {fetch_pc[ADDR_W-1:OFF], OFF zeros} into mem_pc.
    - Assert mem_en, go to MISS.
    - Rollback in the same cycle does not suppress the request.
  - MISS:
    - Hold mem_en=1 and mem_pc stable until mem_done=1.
    - On mem_done: mem_en<=0; write data[idx]<=mem_line, tag[idx]<=latched tag, valid[idx]<=1; go to WAIT.
  - WAIT:
    - One cycle with mem_en=0, so the memory controller sees mem_en low while it clears its done flag.
    - Then go to IDLE; the next cycle can hit on the installed line.
- Rollback: ignored by the FSM. An in-flight miss completes and installs the line, because the memory controller cannot abort a line fetch. Fetch re-requests the new pc afterwards.
- Miss latency: request to first possible hit = memory-controller line time + 2 cycles.
- Simultaneous events:
  - mem_done and fetch_en in the same cycle: no hit is reported (state≠IDLE); fetch retries.
  - Same index, different tag: the new line overwrites the old entry (no victim buffer).
- rdy=0: FSM, arrays and outputs hold. fetch_hit is still combinationally evaluated but gated by fetch_en.
- Reset (rst=0, asynchronous):
  - state=IDLE, mem_en=0, mem_pc=0, all valid=0.
  - Tag and data arrays are not reset.
  - Reset mid-miss abandons the request; a later mem_done pulse while in IDLE is ignored.

Optional Feature:
- ICACHE_STAT_EN
  - Defined: adds output ports hit_cnt (32) and miss_cnt (32), both reset to 0.
    - hit_cnt increments on each cycle with rdy & fetch_hit.
    - miss_cnt increments on each IDLE→MISS transition.
    - Both wrap modulo 2^32.
  - Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch_en=1, fetch_pc=0x00000104.
  - Required: fetch_hit=0; mem_en=1, mem_pc=0x00000100 next cycle.
  - Then: drive mem_done with mem_line bytes i=i; after the WAIT cycle, fetch_hit=1, fetch_inst=0x07060504.
- Same-line hits:
  - Stimulus: fetch_pc 0x100, 0x13C back-to-back.
  - Required: fetch_hit=1 both cycles, inst 0x03020100 and 0x3F3E3D3C, mem_en stays 0.
- Conflict eviction:
  - Stimulus: after filling 0x100, fetch 0x500 (same index 4, different tag).
  - Required: miss with mem_pc=0x500; after fill, 0x100 misses again.
- Rollback mid-miss:
  - Stimulus: assert rollback two cycles after mem_en rises.
  - Required: mem_en held until mem_done; line installed; a subsequent fetch of that line hits.
- Reset mid-miss:
  - Stimulus: pull rst low while in MISS, release, then pulse mem_done.
  - Required: mem_en=0 immediately; no valid bit set; a fetch of the old address misses.
- Stall:
  - Stimulus: rdy=0 for 5 cycles while in MISS, with mem_done held low.
  - Required: mem_en and mem_pc stable; with ICACHE_STAT_EN, miss_cnt=1 and unchanged.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with a combinational hit path and a single outstanding line fill.
// Optional hit/miss counters are compiled in when ICACHE_STAT_EN is defined.
module icache_fetch #(
    parameter int LINE_BYTES = 64,
    parameter int SET_NUM    = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    fetch_en,
    input  logic [ADDR_W-1:0]       fetch_pc,
    output logic                    fetch_hit,
    output logic [31:0]             fetch_inst,
    output logic                    mem_en,
    output logic [ADDR_W-1:0]       mem_pc,
    input  logic                    mem_done,
    input  logic [8*LINE_BYTES-1:0] mem_line
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
`endif
);
    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int IDX    = $clog2(SET_NUM);
    localparam int TAG_W  = ADDR_W - OFF - IDX;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int WORDS  = LINE_BYTES / 4;
    localparam int WOFF_W = (OFF > 2) ? OFF - 2 : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_MISS, ST_WAIT} state_t;

    state_t              state_q, state_d;
    logic                mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]   mem_pc_q, mem_pc_d;
    logic [SET_NUM-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q  [SET_NUM];
    logic [LINE_W-1:0]   data_q [SET_NUM];

    logic [IDX-1:0]      f_idx;
    logic [TAG_W-1:0]    f_tag;
    logic [WOFF_W-1:0]   f_word;
    logic [IDX-1:0]      m_idx;
    logic [TAG_W-1:0]    m_tag;
    logic [LINE_W-1:0]   rd_line;
    logic [31:0]         line_words [WORDS];
    logic                fill_done;

    assign f_idx   = fetch_pc[OFF+IDX-1:OFF];
    assign f_tag   = fetch_pc[ADDR_W-1:OFF+IDX];
    assign m_idx   = mem_pc_q[OFF+IDX-1:OFF];
    assign m_tag   = mem_pc_q[ADDR_W-1:OFF+IDX];
    assign rd_line = data_q[f_idx];

    generate
        if (OFF > 2) begin : g_word_sel
            assign f_word = fetch_pc[OFF-1:2];
        end else begin : g_single_word
            assign f_word = '0;
        end
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
            assign line_words[gi] = rd_line[32*gi +: 32];
        end
    endgenerate

    assign fetch_hit  = fetch_en & valid_q[f_idx] & (tag_q[f_idx] == f_tag) & (state_q == ST_IDLE);
    assign fetch_inst = line_words[f_word];
    assign mem_en     = mem_en_q;
    assign mem_pc     = mem_pc_q;
    assign fill_done  = rdy & (state_q == ST_MISS) & mem_done;

    // Rollback is deliberately not an input to the FSM: the controller cannot abort a fill.
    logic unused_ok;
    assign unused_ok = ^{rollback, fetch_pc[1:0]};

    always_comb begin
        state_d  = state_q;
        mem_en_d = mem_en_q;
        mem_pc_d = mem_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_en && !fetch_hit) begin
                    mem_pc_d = {fetch_pc[ADDR_W-1:OFF], {OFF{1'b0}}};
                    mem_en_d = 1'b1;
                    state_d  = ST_MISS;
                end
            end
            ST_MISS: begin
                if (mem_done) begin
                    mem_en_d = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            mem_en_q <= 1'b0;
            mem_pc_q <= '0;
            valid_q  <= '0;
        end else if (rdy) begin
            state_q  <= state_d;
            mem_en_q <= mem_en_d;
            mem_pc_q <= mem_pc_d;
            if (fill_done) begin
                valid_q[m_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[m_idx] <= mem_line;
            tag_q[m_idx]  <= m_tag;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy) begin
            if (fetch_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (state_q == ST_IDLE && state_d == ST_MISS) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule
